// File: rtl/mult32_seq_pkg.sv
// Shared definitions for the mult32_seq shift-add multiplier and its ALU stall logic.
// Holds the FSM state type, iteration count and datapath width.
package mult32_seq_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MUL_ITERS = 32;
  localparam int unsigned CNT_W     = $clog2(MUL_ITERS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Partial-product select: the multiplicand contributes only when the current multiplier bit is set.
  function automatic logic [DATA_W-1:0] gate_operand(input logic [DATA_W-1:0] op,
                                                      input logic              en);
    return op & {DATA_W{en}};
  endfunction

endpackage

// File: rtl/mult32_seq_if.sv
// Operand/result handshake bundle between the ALU operand latch, mult32_seq and writeback.
// master = ALU side, slave = multiplier side.
interface mult32_seq_if;
  import mult32_seq_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] product;
  logic              busy;

  modport master (
    output in_valid,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  product,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output product,
    output busy
  );

endinterface

// File: rtl/mult32_seq_add32.sv
// 32-bit adder used for the accumulate step of mult32_seq.
// Byte-sliced ripple: each slice consumes the carry of the slice below it.
module mult32_seq_add32
  import mult32_seq_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  localparam int unsigned SLICE_W = 8;
  localparam int unsigned SLICES  = DATA_W / SLICE_W;

  logic               carry;
  logic [SLICE_W:0]   slice_sum;

  always_comb begin
    sum       = '0;
    carry     = cin;
    slice_sum = '0;
    for (int unsigned i = 0; i < SLICES; i++) begin
      slice_sum = {1'b0, a[i*SLICE_W +: SLICE_W]}
                + {1'b0, b[i*SLICE_W +: SLICE_W]}
                + {{SLICE_W{1'b0}}, carry};
      sum[i*SLICE_W +: SLICE_W] = slice_sum[SLICE_W-1:0];
      carry                     = slice_sum[SLICE_W];
    end
    cout = carry;
  end

endmodule

// File: rtl/mult32_seq.sv
// Multi-cycle 32x32 shift-add multiplier returning the low 32 bits of a*b.
// One multiplier bit per cycle; optional early exit once the remaining multiplier bits are zero.
module mult32_seq
  import mult32_seq_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  mult32_seq_if.slave  bus
);

  state_t            state;
  state_t            state_nx;

  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] a_sh;
  logic [DATA_W-1:0] b_sh;
  logic [CNT_W-1:0]  cnt;

  logic              accept;
  logic              step;
  logic [DATA_W-1:0] addend;
  logic [DATA_W-1:0] add_sum;
  logic              add_cout_unused;

  assign addend = gate_operand(a_sh, b_sh[0]);

  mult32_seq_add32 u_add32 (
    .a    (acc),
    .b    (addend),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    accept        = 1'b0;
    step          = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept   = 1'b1;
          state_nx = ST_BUSY;
        end
      end
      ST_BUSY: begin
        bus.busy = 1'b1;
        // Early exit skips the (zero) add; the fixed count still caps the run at MUL_ITERS.
        if (EARLY_EXIT && (b_sh == '0)) begin
          state_nx = ST_DONE;
        end else begin
          step = 1'b1;
          if (cnt == CNT_LAST) begin
            state_nx = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      a_sh <= '0;
      b_sh <= '0;
      cnt  <= '0;
    end else if (accept) begin
      acc  <= '0;
      a_sh <= bus.a;
      b_sh <= bus.b;
      cnt  <= '0;
    end else if (step) begin
      acc  <= add_sum;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + 1'b1;
    end
  end

  // acc only moves on accept/step, so the result holds through DONE and the following IDLE.
  assign bus.product = acc;

endmodule

// File: tb/tb_mult32_seq.sv
// Self-checking bench for mult32_seq: fixed-iteration and early-exit instances,
// directed vector table, backpressure, mid-operation reset and random traffic.
module tb_mult32_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mult32_seq_if bus0 ();
  mult32_seq_if bus1 ();

  mult32_seq #(.EARLY_EXIT(1'b0)) u0 (.clk(clk), .rst(rst), .bus(bus0));
  mult32_seq #(.EARLY_EXIT(1'b1)) u1 (.clk(clk), .rst(rst), .bus(bus1));

  int errors = 0;
  int checks = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] prod;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int hi_lat(input logic [31:0] b);
    if (b == 32'd0) return 1;
    for (int i = 31; i >= 0; i--) begin
      if (b[i]) return (i + 2 > 32) ? 32 : i + 2;
    end
    return 1;
  endfunction

  // Scoreboard monitors: a product is consumed when out_valid and out_ready are both high.
  always @(negedge clk) begin
    logic [31:0] e;
    if (bus0.out_valid === 1'b1 && bus0.out_ready === 1'b1) begin
      if (q0.size() == 0) begin
        chk("sb0_unexpected", 32'd1, 32'd0);
      end else begin
        e = q0.pop_front();
        chk("sb0_product", bus0.product, e);
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] e;
    if (bus1.out_valid === 1'b1 && bus1.out_ready === 1'b1) begin
      if (q1.size() == 0) begin
        chk("sb1_unexpected", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        chk("sb1_product", bus1.product, e);
      end
    end
  end

  task automatic push_exp(input int sel, input logic [31:0] e);
    if (sel == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  task automatic start_txn(virtual mult32_seq_if vif, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (vif.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("in_ready_timeout", 32'd0, 32'd1);
    vif.a        = a;
    vif.b        = b;
    vif.in_valid = 1'b1;
    @(posedge clk);
    #1;
    vif.in_valid = 1'b0;
  endtask

  task automatic wait_done(virtual mult32_seq_if vif, output int lat);
    lat = 0;
    while (vif.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (vif.out_valid !== 1'b1) chk("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic finish_txn(virtual mult32_seq_if vif);
    vif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    vif.out_ready = 1'b0;
    chk("out_valid_1wide", {31'd0, vif.out_valid}, 32'd0);
  endtask

  task automatic do_txn(virtual mult32_seq_if vif, input int sel,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] e,
                        input int exp_lat, input int gap);
    int lat;
    push_exp(sel, e);
    start_txn(vif, a, b);
    wait_done(vif, lat);
    chk("latency", 32'(lat), 32'(exp_lat));
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    finish_txn(vif);
  endtask

  vec_t vecs[8];

  initial begin
    logic [31:0] ra, rb;
    int          sa, lat;

    vecs[0] = '{32'd3,        32'd5,        32'd15,        32};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,  32};
    vecs[2] = '{32'h80000000, 32'd2,        32'h00000000,  32};
    vecs[3] = '{32'd0,        32'h00001234, 32'h00000000,  32};
    vecs[4] = '{32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001,  32};
    vecs[5] = '{32'd7,        32'h00000010, 32'h00000070,  32};
    vecs[6] = '{32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE,  32};
    vecs[7] = '{32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1,  32};

    bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst0_in_ready",  {31'd0, bus0.in_ready},  32'd1);
    chk("rst0_out_valid", {31'd0, bus0.out_valid}, 32'd0);
    chk("rst0_busy",      {31'd0, bus0.busy},      32'd0);
    chk("rst0_product",   bus0.product,            32'd0);
    chk("rst1_in_ready",  {31'd0, bus1.in_ready},  32'd1);
    chk("rst1_product",   bus1.product,            32'd0);

    for (int i = 0; i < 8; i++) begin
      do_txn(bus0, 0, vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].lat, 0);
    end

    // Early-exit corners.
    do_txn(bus1, 1, 32'd0, 32'd0,        32'd0,        1,  0);
    do_txn(bus1, 1, 32'd7, 32'h00000010, 32'h00000070, 6,  0);
    do_txn(bus1, 1, 32'd1, 32'h80000000, 32'h80000000, 32, 0);
    do_txn(bus1, 1, 32'd5, 32'd1,        32'd5,        2,  1);

    // Backpressure: result held, new operands refused.
    push_exp(0, 32'd42);
    start_txn(bus0, 32'd6, 32'd7);
    wait_done(bus0, lat);
    chk("bp_latency", 32'(lat), 32'd32);
    bus0.a = 32'd1; bus0.b = 32'd1; bus0.in_valid = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", {31'd0, bus0.out_valid}, 32'd1);
      chk("bp_product",   bus0.product,            32'd42);
      chk("bp_in_ready",  {31'd0, bus0.in_ready},  32'd0);
      chk("bp_busy",      {31'd0, bus0.busy},      32'd1);
    end
    bus0.in_valid = 1'b0;
    finish_txn(bus0);
    chk("bp_product_held", bus0.product, 32'd42);
    @(posedge clk);
    #1;
    chk("bp_not_accepted", {31'd0, bus0.busy}, 32'd0);

    // Reset during iteration 15 aborts; the aborted result must never surface.
    start_txn(bus0, 32'd9, 32'd9);
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_in_ready",  {31'd0, bus0.in_ready},  32'd1);
    chk("mid_rst_out_valid", {31'd0, bus0.out_valid}, 32'd0);
    chk("mid_rst_busy",      {31'd0, bus0.busy},      32'd0);
    chk("mid_rst_product",   bus0.product,            32'd0);
    do_txn(bus0, 0, 32'd2, 32'd3, 32'd6, 32, 0);

    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 2))
        0: begin
          ra = $urandom;
          rb = $urandom;
        end
        1: begin
          sa = int'($urandom_range(0, 200)) - 100;
          ra = 32'(sa);
          sa = int'($urandom_range(0, 200)) - 100;
          rb = 32'(sa);
        end
        default: begin
          ra = $urandom;
          rb = $urandom >> $urandom_range(0, 31);
        end
      endcase
      do_txn(bus0, 0, ra, rb, ra * rb, 32, int'($urandom_range(0, 3)));
    end

    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      rb = (n % 8 == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      do_txn(bus1, 1, ra, rb, ra * rb, hi_lat(rb), int'($urandom_range(0, 2)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb0_drained", 32'(q0.size()), 32'd0);
    chk("sb1_drained", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
